// File: rtl/json_scan_ctrl.sv
// Purpose : streaming JSON structural scanner; tracks nesting, string/escape
//           context and emits one token per structural byte, or the first error.
// Latency : token and done/err appear one cycle after the byte is accepted.
// Backpr. : one-entry token register; in_ready drops while a token is stalled.
// Ports   : clk/rst_n (async active-low); start pulse clears state and begins a
//           document; in_valid/in_ready/in_data/in_last byte stream in;
//           tok_valid/tok_ready/tok_kind/tok_idx/tok_depth token stream out;
//           busy, sticky done, sticky err with err_kind/err_idx.
module json_scan_ctrl #(
  parameter int MAX_DEPTH = 32,
  parameter int IDX_W     = 32,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               tok_valid,
  input  logic               tok_ready,
  output logic [2:0]         tok_kind,
  output logic [IDX_W-1:0]   tok_idx,
  output logic [DEPTH_W-1:0] tok_depth,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_kind,
  output logic [IDX_W-1:0]   err_idx
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_STR  = 3'd2,
    S_ESC  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [2:0] K_OBJ_OPEN  = 3'd0;
  localparam logic [2:0] K_OBJ_CLOSE = 3'd1;
  localparam logic [2:0] K_ARR_OPEN  = 3'd2;
  localparam logic [2:0] K_ARR_CLOSE = 3'd3;
  localparam logic [2:0] K_STR_OPEN  = 3'd4;
  localparam logic [2:0] K_STR_CLOSE = 3'd5;
  localparam logic [2:0] K_COLON     = 3'd6;
  localparam logic [2:0] K_COMMA     = 3'd7;

  localparam logic [2:0] E_NONE       = 3'd0;
  localparam logic [2:0] E_UNBALANCED = 3'd1;
  localparam logic [2:0] E_MISMATCH   = 3'd2;
  localparam logic [2:0] E_DEPTH      = 3'd3;
  localparam logic [2:0] E_EOF_STR    = 3'd4;
  localparam logic [2:0] E_EOF_OPEN   = 3'd5;
  localparam logic [2:0] E_CTRL_STR   = 3'd6;

  localparam logic [7:0] C_LBRACE = 8'h7B;
  localparam logic [7:0] C_RBRACE = 8'h7D;
  localparam logic [7:0] C_LBRACK = 8'h5B;
  localparam logic [7:0] C_RBRACK = 8'h5D;
  localparam logic [7:0] C_QUOTE  = 8'h22;
  localparam logic [7:0] C_BSLASH = 8'h5C;
  localparam logic [7:0] C_COLON  = 8'h3A;
  localparam logic [7:0] C_COMMA  = 8'h2C;

  localparam logic [DEPTH_W-1:0] L_MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam int                 STK_N   = 1 << DEPTH_W;

  state_t               r_state;
  state_t               w_nxt_state;
  logic [DEPTH_W-1:0]   r_depth;
  logic [STK_N-1:0]     r_stack;    // bit d holds type of level d+1: 1=object, 0=array
  logic [IDX_W-1:0]     r_idx;
  logic                 r_tok_vld;
  logic [2:0]           r_tok_kind;
  logic [IDX_W-1:0]     r_tok_idx;
  logic [DEPTH_W-1:0]   r_tok_depth;
  logic                 r_done;
  logic                 r_err;
  logic [2:0]           r_err_kind;
  logic [IDX_W-1:0]     r_err_idx;

  logic                 w_busy;
  logic                 w_acc;
  logic [DEPTH_W-1:0]   w_top_ptr;
  logic                 w_top_is_obj;
  logic                 w_emit;
  logic [2:0]           w_kind;
  logic [DEPTH_W-1:0]   w_tdepth;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_is_obj;
  logic                 w_err_set;
  logic [2:0]           w_err_kind;
  logic                 w_done_set;
  logic [DEPTH_W-1:0]   w_depth_after;

  assign w_busy       = (r_state == S_SCAN) || (r_state == S_STR) || (r_state == S_ESC);
  assign in_ready     = w_busy && !start && (!r_tok_vld || tok_ready);
  assign w_acc        = in_valid && in_ready;
  assign w_top_ptr    = r_depth - DEPTH_W'(1);
  assign w_top_is_obj = r_stack[w_top_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_emit        = 1'b0;
    w_kind        = K_OBJ_OPEN;
    w_tdepth      = r_depth;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_is_obj      = 1'b0;
    w_err_set     = 1'b0;
    w_err_kind    = E_NONE;
    w_done_set    = 1'b0;
    w_depth_after = r_depth;
    if (start) begin
      w_nxt_state = S_SCAN;
    end else if (w_acc) begin
      case (r_state)
        S_SCAN: begin
          case (in_data)
            C_LBRACE, C_LBRACK: begin
              w_is_obj = (in_data == C_LBRACE);
              if (r_depth == L_MAX_D) begin
                w_err_set  = 1'b1;
                w_err_kind = E_DEPTH;
              end else begin
                w_push   = 1'b1;
                w_emit   = 1'b1;
                w_kind   = w_is_obj ? K_OBJ_OPEN : K_ARR_OPEN;
                w_tdepth = r_depth + DEPTH_W'(1);
              end
            end
            C_RBRACE, C_RBRACK: begin
              w_is_obj = (in_data == C_RBRACE);
              if (r_depth == '0) begin
                w_err_set  = 1'b1;
                w_err_kind = E_UNBALANCED;
              end else if (w_top_is_obj != w_is_obj) begin
                w_err_set  = 1'b1;
                w_err_kind = E_MISMATCH;
              end else begin
                // close token carries the depth of the level being closed
                w_pop  = 1'b1;
                w_emit = 1'b1;
                w_kind = w_is_obj ? K_OBJ_CLOSE : K_ARR_CLOSE;
              end
            end
            C_QUOTE: begin
              w_emit      = 1'b1;
              w_kind      = K_STR_OPEN;
              w_nxt_state = S_STR;
            end
            C_COLON: begin
              w_emit = 1'b1;
              w_kind = K_COLON;
            end
            C_COMMA: begin
              w_emit = 1'b1;
              w_kind = K_COMMA;
            end
            default: ;
          endcase
        end
        S_STR: begin
          if (in_data == C_QUOTE) begin
            w_emit      = 1'b1;
            w_kind      = K_STR_CLOSE;
            w_nxt_state = S_SCAN;
          end else if (in_data == C_BSLASH) begin
            w_nxt_state = S_ESC;
          end else if (in_data < 8'h20) begin
            w_err_set  = 1'b1;
            w_err_kind = E_CTRL_STR;
          end
        end
        S_ESC: begin
          w_nxt_state = S_STR;
        end
        default: ;
      endcase

      if (w_push) begin
        w_depth_after = r_depth + DEPTH_W'(1);
      end else if (w_pop) begin
        w_depth_after = r_depth - DEPTH_W'(1);
      end

      // byte-level errors outrank the end-of-document checks
      if (!w_err_set && in_last) begin
        if ((w_nxt_state == S_STR) || (w_nxt_state == S_ESC)) begin
          w_err_set  = 1'b1;
          w_err_kind = E_EOF_STR;
        end else if (w_depth_after != '0) begin
          w_err_set  = 1'b1;
          w_err_kind = E_EOF_OPEN;
        end else begin
          w_done_set  = 1'b1;
          w_nxt_state = S_DONE;
        end
      end

      // the offending byte never produces a token
      if (w_err_set) begin
        w_emit      = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_nxt_state = S_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth     <= '0;
      r_stack     <= '0;
      r_idx       <= '0;
      r_tok_vld   <= 1'b0;
      r_tok_kind  <= '0;
      r_tok_idx   <= '0;
      r_tok_depth <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_kind  <= '0;
      r_err_idx   <= '0;
    end else if (start) begin
      r_depth     <= '0;
      r_stack     <= '0;
      r_idx       <= '0;
      r_tok_vld   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_kind  <= '0;
      r_err_idx   <= '0;
    end else if (w_acc) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_push) begin
        r_stack[r_depth] <= w_is_obj;
        r_depth          <= r_depth + DEPTH_W'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DEPTH_W'(1);
      end
      // acceptance implies the output register is empty or draining now
      r_tok_vld <= w_emit;
      if (w_emit) begin
        r_tok_kind  <= w_kind;
        r_tok_idx   <= r_idx;
        r_tok_depth <= w_tdepth;
      end
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_kind <= w_err_kind;
        r_err_idx  <= r_idx;
      end
      if (w_done_set) begin
        r_done <= 1'b1;
      end
    end else if (tok_ready) begin
      r_tok_vld <= 1'b0;
    end
  end

  assign busy      = w_busy;
  assign tok_valid = r_tok_vld;
  assign tok_kind  = r_tok_kind;
  assign tok_idx   = r_tok_idx;
  assign tok_depth = r_tok_depth;
  assign done      = r_done;
  assign err       = r_err;
  assign err_kind  = r_err_kind;
  assign err_idx   = r_err_idx;

endmodule

// File: doc/json_scan_ctrl.md
Name: json_scan_ctrl

Overview:
- Streaming structural scanner and sequencing controller for the JSON decode path.
- Consumes a document as a byte stream and tracks object/array nesting on a bit stack.
- Tracks string and escape context, and emits one structural token per significant byte, tagged with byte index and depth.
- Reports the first structural error with kind and byte index, mirroring the software decoder's error/index model, so downstream value builders see a pre-validated token sequence.

Parameters:
- MAX_DEPTH, 32: maximum nesting depth of objects and arrays combined.
- IDX_W, 32: width of the byte index counter.
- DEPTH_W, $clog2(MAX_DEPTH+1): width of the depth outputs (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  pulse; clears all state and begins a new document.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  input byte.
- in_last  in  1  marks the final byte of the document.
- tok_valid  out  1  token valid.
- tok_ready  in  1  token consumed when tok_valid && tok_ready.
- tok_kind  out  3  token kind: 0 OBJ_OPEN, 1 OBJ_CLOSE, 2 ARR_OPEN, 3 ARR_CLOSE, 4 STR_OPEN, 5 STR_CLOSE, 6 COLON, 7 COMMA.
- tok_idx  out  IDX_W  byte index of the token.
- tok_depth  out  DEPTH_W  nesting depth attached to the token.
- busy  out  1  high in states SCAN, STR, ESC.
- done  out  1  sticky; document completed without error.
- err  out  1  sticky; error detected.
- err_kind  out  3  0 NONE, 1 UNBALANCED_CLOSE, 2 MISMATCH, 3 DEPTH_OVERFLOW, 4 EOF_IN_STRING, 5 EOF_UNCLOSED, 6 CTRL_IN_STRING.
- err_idx  out  IDX_W  byte index of the offending byte.

Behaviour:
- Reset values: all outputs 0; state IDLE; depth 0; index 0; stack cleared.
- States: IDLE, SCAN, STR, ESC, DONE, ERR.
- start, from any state: next cycle is SCAN; clears index, depth, done, err, err_kind, err_idx; drops any pending token.
  - start has priority over everything else; in_ready is 0 in the start cycle.
- in_ready = busy && !start && (!tok_valid || tok_ready). One-entry output register; full throughput when tok_ready is held high.
- Latency: a token appears on the cycle after its byte is accepted. The index increments per accepted byte and wraps modulo 2^IDX_W.
- SCAN, per byte:
  - '{' or '[': depth==MAX_DEPTH gives DEPTH_OVERFLOW; otherwise push (1=object, 0=array), depth+1, emit OPEN with tok_depth = new depth.
  - '}' or ']': depth==0 gives UNBALANCED_CLOSE; stack-top type differs gives MISMATCH; otherwise emit CLOSE with tok_depth = depth before pop, then pop.
  - '"': emit STR_OPEN, go to STR.
  - ':' and ',': emit COLON/COMMA at current depth.
  - All other bytes (whitespace, literals, digits): consumed, no token.
- STR, per byte:
  - '"': emit STR_CLOSE, return to SCAN.
  - '\': go to ESC.
  - Byte < 0x20: CTRL_IN_STRING.
  - Else: consumed, no token.
- ESC: any byte is consumed, return to STR. Escape content is not validated.
- Error:
  - No token is emitted for the offending byte.
  - err, err_kind and err_idx are set the cycle after acceptance; state goes to ERR and in_ready goes to 0.
  - An already-pending token still drains.
  - First error wins.
- in_last checks, evaluated after the byte's normal handling:
  - Byte-level errors take priority.
  - If in_last and state is STR or ESC after the byte: EOF_IN_STRING, with err_idx = index of the last byte.
  - If in_last and depth>0 after the byte: EOF_UNCLOSED.
  - Otherwise done=1 on the same cycle the last byte's token (if any) appears; state goes to DONE and in_ready goes to 0.
- A document with no structural bytes completes with done=1 and no tokens.
- tok_* is held stable while tok_valid && !tok_ready.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

Test Plan:
1. Normal document.
   - Stimulus: start; stream `{"a":[1,2]}` with in_last on '}'; tok_ready=1.
   - Response: tokens (kind,idx,depth) = (0,0,1) (4,1,1) (5,3,1) (6,4,1) (2,5,2) (7,7,2) (3,9,2) (1,10,1); done=1; err=0.
2. Bracket mismatch.
   - Stimulus: stream `[}`.
   - Response: ARR_OPEN idx0 d1; then err=1, err_kind=2, err_idx=1; no token for idx1; in_ready=0 until start.
3. Escaped quote.
   - Stimulus: stream `"a\"b"` with in_last on the final '"'.
   - Response: only STR_OPEN idx0 and STR_CLOSE idx5; done=1.
4. Depth overflow (MAX_DEPTH=4).
   - Stimulus: stream `[[[[[`.
   - Response: ARR_OPEN depths 1..4 at idx 0..3; err_kind=3, err_idx=4.
5. Backpressure.
   - Stimulus: repeat scenario 1 with tok_ready=0 for 5 cycles after the first token.
   - Response: in_ready=0 and tok_* stable throughout; identical token sequence; done=1.
6. Unterminated string, then recovery.
   - Stimulus: stream `{"ab` with in_last on 'b'.
   - Response: err_kind=4, err_idx=3.
   - Then: start mid-stream of a new document clears err and the index restarts at 0; rst_n pulsed mid-document zeroes all outputs.
